// File: rtl/moonbase_bus_pkg.sv
// Shared constants and address layout for the moonbase bus responder.
// Bit positions of the CPU io_out bus and the loader nibble-address fields.
package moonbase_bus_pkg;

    localparam int BUS_STROBE   = 7;
    localparam int BUS_SPACE    = 6;
    localparam int BUS_RAM_WE_N = 5;
    localparam int BUS_DEV_WE_N = 4;

    localparam logic SPACE_CODE = 1'b1;
    localparam logic SPACE_DATA = 1'b0;

    localparam int NIB_W = 4;

    localparam int LD_ADDR_W    = 9;
    localparam int LD_SPACE_BIT = 8;
    localparam int LD_LATCH_MSB = 7;
    localparam int LD_LATCH_LSB = 1;
    localparam int LD_NIB_BIT   = 0;

    typedef struct packed {
        logic       space;
        logic [6:0] addr;
        logic       nib;
    } nib_addr_t;

    function automatic nib_addr_t mk_nib_addr(
        input logic       space,
        input logic [6:0] addr,
        input logic       nib
    );
        nib_addr_t a;
        a.space = space;
        a.addr  = addr;
        a.nib   = nib;
        return a;
    endfunction

endpackage

// File: rtl/moonbase_nib_ram.sv
// Nibble-wide RAM, one synchronous write port and one asynchronous read port.
// Contents are never reset; a read of the address being written returns old data.
module moonbase_nib_ram
    import moonbase_bus_pkg::*;
#(
    parameter int AW = 9
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [NIB_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [NIB_W-1:0] rdata
);

    logic [NIB_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/moonbase_bus_responder.sv
// Target side of the moonbase CPU bus: address latch, code/data nibble RAM, device port, loader.
// Optional statistics counters are built when MOONBASE_RESP_STATS_EN is defined.
module moonbase_bus_responder
    import moonbase_bus_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        bus_out,
    output logic [5:0]        bus_in,
    output logic [ADDR_W-1:0] dev_addr,
    input  logic [1:0]        dev_rd,
    output logic              dev_wr_valid,
    output logic [NIB_W-1:0]  dev_wr_data,
    output logic              dev_wr_nib,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W+1:0] ld_addr,
    input  logic [NIB_W-1:0]  ld_data
`ifdef MOONBASE_RESP_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_ram_wr,
    output logic [STAT_W-1:0] stat_dev_wr,
    output logic [STAT_W-1:0] stat_fetch
`endif
);

    localparam int MEM_AW = ADDR_W + 2;

    localparam logic [0:0] ST_ADDR = 1'b0;
    localparam logic [0:0] ST_DATA = 1'b1;

    logic [0:0]        state_q;
    logic [ADDR_W-1:0] latch_q;
    logic              nib;
    logic              strobe;
    logic              cpu_ram_wr;
    logic              cpu_dev_wr;
    logic              ld_fire;
    logic              ram_we;
    logic [MEM_AW-1:0] cpu_addr;
    logic [MEM_AW-1:0] ram_waddr;
    logic [NIB_W-1:0]  ram_wdata;
    logic [NIB_W-1:0]  ram_rdata;

    assign strobe     = bus_out[BUS_STROBE];
    assign nib        = (state_q == ST_DATA);
    assign cpu_addr   = {bus_out[BUS_SPACE], latch_q, nib};
    assign cpu_ram_wr = !strobe && !bus_out[BUS_RAM_WE_N];
    assign cpu_dev_wr = !strobe && !bus_out[BUS_DEV_WE_N];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ADDR;
            latch_q <= '0;
        end else if (strobe) begin
            state_q <= ST_ADDR;
            latch_q <= bus_out[ADDR_W-1:0];
        end else begin
            state_q <= ST_DATA;
        end
    end

    // CPU write owns the RAM port; the loader is stalled for that cycle.
    assign ld_ready  = !cpu_ram_wr;
    assign ld_fire   = ld_valid && ld_ready && !reset;
    assign ram_we    = (cpu_ram_wr && !reset) || ld_fire;
    assign ram_waddr = cpu_ram_wr ? cpu_addr : ld_addr;
    assign ram_wdata = cpu_ram_wr ? bus_out[NIB_W-1:0] : ld_data;

    moonbase_nib_ram #(
        .AW(MEM_AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(cpu_addr),
        .rdata(ram_rdata)
    );

    assign bus_in   = {dev_rd, ram_rdata};
    assign dev_addr = latch_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            dev_wr_valid <= 1'b0;
            dev_wr_data  <= '0;
            dev_wr_nib   <= 1'b0;
        end else begin
            dev_wr_valid <= cpu_dev_wr;
            if (cpu_dev_wr) begin
                dev_wr_data <= bus_out[NIB_W-1:0];
                dev_wr_nib  <= nib;
            end
        end
    end

`ifdef MOONBASE_RESP_STATS_EN
    logic fetch_arm_q;
    logic fetch_hit;

    // A fetch is credited once the cycle after the strobe shows a code-space read.
    assign fetch_hit = fetch_arm_q && !strobe
                    && (bus_out[BUS_SPACE] == SPACE_CODE);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_arm_q <= 1'b0;
            stat_ram_wr <= '0;
            stat_dev_wr <= '0;
            stat_fetch  <= '0;
        end else begin
            fetch_arm_q <= strobe;
            if (cpu_ram_wr && (stat_ram_wr != '1)) begin
                stat_ram_wr <= stat_ram_wr + 1'b1;
            end
            if (cpu_dev_wr && (stat_dev_wr != '1)) begin
                stat_dev_wr <= stat_dev_wr + 1'b1;
            end
            if (fetch_hit && (stat_fetch != '1)) begin
                stat_fetch <= stat_fetch + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_moonbase_bus_responder.sv
// Bench for moonbase_bus_responder: directed test-plan steps then random bus traffic.
// Stats checks are compiled in when MOONBASE_RESP_STATS_EN is defined.
module tb_moonbase_bus_responder;

    logic       clk;
    logic       reset;
    logic [7:0] bus_out;
    logic [5:0] bus_in;
    logic [6:0] dev_addr;
    logic [1:0] dev_rd;
    logic       dev_wr_valid;
    logic [3:0] dev_wr_data;
    logic       dev_wr_nib;
    logic       ld_valid;
    logic       ld_ready;
    logic [8:0] ld_addr;
    logic [3:0] ld_data;

    int checks = 0;
    int errors = 0;

`ifdef MOONBASE_RESP_STATS_EN
    logic [15:0] stat_ram_wr, stat_dev_wr, stat_fetch;
    logic [5:0]  s_bus_in;
    logic [6:0]  s_dev_addr;
    logic        s_dev_wr_valid, s_dev_wr_nib, s_ld_ready;
    logic [3:0]  s_dev_wr_data;
    logic [1:0]  s_ram_wr, s_dev_wr, s_fetch;
`endif

    moonbase_bus_responder dut (
        .clk         (clk),
        .reset       (reset),
        .bus_out     (bus_out),
        .bus_in      (bus_in),
        .dev_addr    (dev_addr),
        .dev_rd      (dev_rd),
        .dev_wr_valid(dev_wr_valid),
        .dev_wr_data (dev_wr_data),
        .dev_wr_nib  (dev_wr_nib),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data)
`ifdef MOONBASE_RESP_STATS_EN
        ,
        .stat_ram_wr (stat_ram_wr),
        .stat_dev_wr (stat_dev_wr),
        .stat_fetch  (stat_fetch)
`endif
    );

`ifdef MOONBASE_RESP_STATS_EN
    moonbase_bus_responder #(.STAT_W(2)) u_sat (
        .clk         (clk),
        .reset       (reset),
        .bus_out     (bus_out),
        .bus_in      (s_bus_in),
        .dev_addr    (s_dev_addr),
        .dev_rd      (dev_rd),
        .dev_wr_valid(s_dev_wr_valid),
        .dev_wr_data (s_dev_wr_data),
        .dev_wr_nib  (s_dev_wr_nib),
        .ld_valid    (ld_valid),
        .ld_ready    (s_ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .stat_ram_wr (s_ram_wr),
        .stat_dev_wr (s_dev_wr),
        .stat_fetch  (s_fetch)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: memory as a nibble array plus what the bus protocol implies.
    logic [3:0] mm [512];
    bit         known [512];
    int         m_latch = 0;
    int         m_nib = 0;
    bit         m_dv = 0;
    int         m_dd = 0;
    int         m_dn = 0;
    int         cnt_ram = 0;
    int         cnt_dev = 0;
    int         cnt_fetch = 0;
    bit         prev_hi = 0;
    logic [3:0] obs_in;
    logic       obs_ready;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic cyc(input logic [7:0] b, input logic rst,
                       input logic lv, input logic [8:0] la,
                       input logic [3:0] ld, input logic [1:0] rd);
        int  idx;
        bit  ram_w, dev_w, rdy;
        @(negedge clk);
        bus_out  = b;
        reset    = rst;
        ld_valid = lv;
        ld_addr  = la;
        ld_data  = ld;
        dev_rd   = rd;
        #2;
        idx   = (b[6] ? 256 : 0) + m_latch * 2 + m_nib;
        ram_w = !b[7] && !b[5];
        dev_w = !b[7] && !b[4];
        rdy   = !ram_w;
        obs_in    = bus_in[3:0];
        obs_ready = ld_ready;
        chk("dev_rd_pass", 32'(bus_in[5:4]), 32'(rd));
        chk("ld_ready", 32'(ld_ready), 32'(rdy));
        if (known[idx]) chk("ram_read", 32'(bus_in[3:0]), 32'(mm[idx]));
        @(posedge clk);
        if (rst) begin
            m_latch = 0; m_nib = 0;
            m_dv = 0; m_dd = 0; m_dn = 0;
            cnt_ram = 0; cnt_dev = 0; cnt_fetch = 0;
            prev_hi = 0;
        end else begin
            if (ram_w) begin
                mm[idx] = b[3:0]; known[idx] = 1; cnt_ram++;
            end else if (lv) begin
                mm[la] = ld; known[la] = 1;
            end
            m_dv = dev_w;
            if (dev_w) begin
                m_dd = int'(b[3:0]); m_dn = m_nib; cnt_dev++;
            end
            if (prev_hi && !b[7] && b[6]) cnt_fetch++;
            prev_hi = b[7];
            if (b[7]) begin
                m_latch = int'(b[6:0]); m_nib = 0;
            end else begin
                m_nib = 1;
            end
        end
        #1;
        chk("dev_addr", 32'(dev_addr), 32'(m_latch));
        chk("dev_wr_valid", 32'(dev_wr_valid), 32'(m_dv));
        chk("dev_wr_data", 32'(dev_wr_data), 32'(m_dd));
        chk("dev_wr_nib", 32'(dev_wr_nib), 32'(m_dn));
`ifdef MOONBASE_RESP_STATS_EN
        chk("stat_ram_wr", 32'(stat_ram_wr), 32'(sat(cnt_ram, 65535)));
        chk("stat_dev_wr", 32'(stat_dev_wr), 32'(sat(cnt_dev, 65535)));
        chk("stat_fetch", 32'(stat_fetch), 32'(sat(cnt_fetch, 65535)));
        chk("sat_ram_wr", 32'(s_ram_wr), 32'(sat(cnt_ram, 3)));
        chk("sat_dev_wr", 32'(s_dev_wr), 32'(sat(cnt_dev, 3)));
`endif
    endtask

    initial begin
        reset = 1'b1; bus_out = 8'h80; dev_rd = 2'b00;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;

        cyc(8'h80, 1, 0, 9'h000, 4'h0, 2'b00);
        cyc(8'h80, 1, 0, 9'h000, 4'h0, 2'b00);
        chk("rst_dev_addr", 32'(dev_addr), 32'h0);
        chk("rst_dev_valid", 32'(dev_wr_valid), 32'h0);

        // Code preload then fetch
        cyc(8'h80, 0, 1, 9'h120, 4'h5, 2'b01);
        cyc(8'h80, 0, 1, 9'h121, 4'hA, 2'b10);
        cyc(8'h90, 0, 0, 9'h000, 4'h0, 2'b00);
        cyc(8'h40, 0, 0, 9'h000, 4'h0, 2'b11);
        chk("t1_code_nib0", 32'(obs_in), 32'h5);
        cyc(8'h40, 0, 0, 9'h000, 4'h0, 2'b00);
        chk("t1_code_nib1", 32'(obs_in), 32'hA);

        // CPU RAM write and read-back
        cyc(8'h83, 0, 0, 9'h000, 4'h0, 2'b00);
        cyc(8'h07, 0, 0, 9'h000, 4'h0, 2'b00);
        cyc(8'h0C, 0, 0, 9'h000, 4'h0, 2'b00);
        cyc(8'h83, 0, 0, 9'h000, 4'h0, 2'b00);
        cyc(8'h30, 0, 0, 9'h000, 4'h0, 2'b00);
        chk("t2_rd_nib0", 32'(obs_in), 32'h7);
        cyc(8'h30, 0, 0, 9'h000, 4'h0, 2'b00);
        chk("t2_rd_nib1", 32'(obs_in), 32'hC);

        // Device write
        cyc(8'hFF, 0, 0, 9'h000, 4'h0, 2'b00);
        cyc(8'h29, 0, 0, 9'h000, 4'h0, 2'b00);
        chk("t3_dev_valid", 32'(dev_wr_valid), 32'h1);
        chk("t3_dev_data", 32'(dev_wr_data), 32'h9);
        chk("t3_dev_nib", 32'(dev_wr_nib), 32'h0);
        chk("t3_dev_addr", 32'(dev_addr), 32'h7F);
        cyc(8'h30, 0, 0, 9'h000, 4'h0, 2'b00);
        chk("t3_dev_pulse", 32'(dev_wr_valid), 32'h0);

        // Loader contention with CPU RAM write
        cyc(8'h85, 0, 0, 9'h000, 4'h0, 2'b00);
        cyc(8'h03, 0, 1, 9'h0A0, 4'h6, 2'b00);
        chk("t4_ready_low", 32'(obs_ready), 32'h0);
        cyc(8'h31, 0, 1, 9'h0A0, 4'h6, 2'b00);
        chk("t4_ready_high", 32'(obs_ready), 32'h1);
        cyc(8'h85, 0, 0, 9'h000, 4'h0, 2'b00);
        cyc(8'h30, 0, 0, 9'h000, 4'h0, 2'b00);
        chk("t4_cpu_landed", 32'(obs_in), 32'h3);
        cyc(8'hD0, 0, 0, 9'h000, 4'h0, 2'b00);
        cyc(8'h30, 0, 0, 9'h000, 4'h0, 2'b00);
        chk("t4_ld_landed", 32'(obs_in), 32'h6);

        // Reset with a write pending; loader ignored under reset
        cyc(8'h80, 0, 1, 9'h044, 4'hE, 2'b00);
        cyc(8'hA2, 0, 0, 9'h000, 4'h0, 2'b00);
        cyc(8'h05, 1, 0, 9'h000, 4'h0, 2'b00);
        chk("t5_latch_clr", 32'(dev_addr), 32'h0);
        cyc(8'h80, 1, 1, 9'h044, 4'h1, 2'b00);
        cyc(8'hA2, 0, 0, 9'h000, 4'h0, 2'b00);
        cyc(8'h30, 0, 0, 9'h000, 4'h0, 2'b00);
        chk("t5_mem_kept", 32'(obs_in), 32'hE);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(8'($urandom), ($urandom_range(0, 49) == 0),
                1'($urandom), 9'($urandom), 4'($urandom),
                2'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
